obi_regfile: RTL and testbench
==============================

Name: obi_regfile

Overview:
Parametrised OBI subordinate register file for the croc user domain. It supports configurable depth, register width, reset values and per-register access modes (RW, RO, W1C, RC), plus byte-enable writes and hardware-side update ports. Illegal accesses return an OBI error response; they never stall or halt simulation. It sits behind the user-domain crossbar as a peripheral control/status block.

Parameters:
NumRegs, 4, number of 32-bit-addressed registers; must be >= 1
RegWidth, 32, implemented bits per register (1..32); reads zero-extend to 32
AddrWidth, 12, low address bits decoded; index = addr[AddrWidth-1:2]; higher bits ignored (window decoded upstream)
RegMode, all RW, logic [NumRegs-1:0][1:0] per register: 0=RW, 1=RO, 2=W1C, 3=RC
ResetVal, '0, logic [NumRegs-1:0][RegWidth-1:0] per-register reset value

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
obi_req_i  in  sbr_obi_req_t  OBI request (croc_pkg)
obi_rsp_o  out  sbr_obi_rsp_t  OBI response
reg_ready_i  in  NumRegs  per-register grant enable; low stalls a legal access to that register
hw_we_i  in  NumRegs  hardware update strobe per register
hw_wdata_i  in  NumRegs x RegWidth  hardware update data
regs_o  out  NumRegs x RegWidth  current register contents
sw_wr_o  out  NumRegs  one-cycle pulse: software write committed to register i
sw_rd_o  out  NumRegs  one-cycle pulse: software read granted on register i

Behaviour:
- Reset: regs_q = ResetVal; rvalid_q, err_q, sw_wr_o, sw_rd_o = 0; rdata_q, rid_q = 0. Reset is asynchronous and may assert mid-transaction; a pending response is dropped.
- Decode: idx = addr[AddrWidth-1:2]. Access is illegal if idx >= NumRegs, or if it is a write (we=1) to an RO or RC register.
- Grant (combinational): gnt = req && (illegal || reg_ready_i[idx]). Illegal accesses are granted immediately, regardless of reg_ready_i.
- Accept event = req && gnt. Exactly one cycle after accept: rvalid=1 for one cycle, with rid = captured aid, err = captured illegal flag, and rdata = register value sampled at the accept edge (pre-update), zero-extended. If err=1, rdata=0. r_optional=0.
- Back-to-back accepts are allowed every cycle. There is no rready and no outstanding queue beyond one response stage.
- Byte-enable mask m: bit j is set iff be[j/8]; the mask is truncated to RegWidth.
- SW write, applied at the accept edge:
  - RW: reg = (reg & ~m) | (wdata & m).
  - W1C: reg = reg & ~(wdata & m).
  - sw_wr_o[idx] pulses in the cycle following accept; it does not pulse on illegal accesses.
- SW read: sw_rd_o[idx] pulses in the cycle following accept. For RC registers, reg is cleared to 0 at the accept edge; rdata returns the pre-clear value.
- HW update, at each edge:
  - RW/RO/RC: hw_we_i[i] sets reg = hw_wdata_i[i].
  - W1C: hw_we_i[i] sets reg |= hw_wdata_i[i] (sticky event set).
- Same-edge collision on one register:
  - RW/RO/RC: HW wins over SW write and over RC clear.
  - W1C: reg = (reg & ~swclr) | hwset, i.e. set wins over clear.
  - The response still returns the pre-update value.
- Illegal access causes no state change and no sw_* pulse. Under `ifndef SYNTHESIS, emit a $warning; never call $stop.
- NumRegs=1: index width is max(1, $clog2(NumRegs)); idx != 0 is out of range.

Decomposition:
- croc_pkg: add typedef reg_mode_e (REG_RW, REG_RO, REG_W1C, REG_RC), 2 bits.
- Sub-module obi_regfile_cell (one register: mode logic, byte mask, HW/SW priority, async-reset FF), instantiated NumRegs times in a generate loop.
- The top level holds decode, grant and the response stage.

Test Plan:
- Reset with ResetVal={4'h0,4'hA,...}, read reg 1 -> rvalid one cycle after gnt, rdata=0x0000000A, err=0.
- Write 0xDEADBEEF be=4'b0101 to RW reg 0 holding 0 -> regs_o[0]=0x00AD00EF, sw_wr_o[0] pulses once.
- W1C reg 2 = 0xFF, SW write 0x0F while hw_we_i[2]=1 with hw_wdata=0x01 in the same cycle -> reg=0xF1, response err=0.
- RC reg 3 = 0x55, read -> rdata=0x55, reg becomes 0, second read returns 0; with simultaneous hw_we=0x77, reg=0x77.
- Write to RO reg or idx=NumRegs -> immediate gnt despite reg_ready_i=0, err=1, rdata=0, regs unchanged, no sw_wr_o.
- reg_ready_i[1]=0 for 3 cycles during a read of reg 1 -> gnt low for 3 cycles, then gnt, and rvalid the next cycle; assert rst_ni between accept and rvalid -> no rvalid emitted.

Source files
------------

// File: rtl/croc_pkg.sv
// Shared OBI subordinate channel types and register access modes for the
// croc user domain.
package croc_pkg;

  localparam int unsigned SbrObiAddrWidth = 32;
  localparam int unsigned SbrObiDataWidth = 32;
  localparam int unsigned SbrObiIdWidth   = 4;

  typedef enum logic [1:0] {
    REG_RW  = 2'd0,
    REG_RO  = 2'd1,
    REG_W1C = 2'd2,
    REG_RC  = 2'd3
  } reg_mode_e;

  typedef struct packed {
    logic [SbrObiAddrWidth-1:0]   addr;
    logic                         we;
    logic [SbrObiDataWidth/8-1:0] be;
    logic [SbrObiDataWidth-1:0]   wdata;
    logic [SbrObiIdWidth-1:0]     aid;
    logic                         a_optional;
  } sbr_obi_a_chan_t;

  typedef struct packed {
    logic            req;
    sbr_obi_a_chan_t a;
  } sbr_obi_req_t;

  typedef struct packed {
    logic [SbrObiDataWidth-1:0] rdata;
    logic [SbrObiIdWidth-1:0]   rid;
    logic                       err;
    logic                       r_optional;
  } sbr_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    sbr_obi_r_chan_t r;
  } sbr_obi_rsp_t;

endpackage

// File: rtl/obi_regfile_cell.sv
// One register of the OBI register file: byte-masked software access,
// hardware update port and the mode-dependent priority between the two.
module obi_regfile_cell
  import croc_pkg::*;
#(
  parameter int unsigned           RegWidth = 32,
  parameter reg_mode_e             Mode     = REG_RW,
  parameter logic [RegWidth-1:0]   ResetVal = '0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                sw_we_i,
  input  logic                sw_re_i,
  input  logic [RegWidth-1:0] sw_wdata_i,
  input  logic [3:0]          sw_be_i,
  input  logic                hw_we_i,
  input  logic [RegWidth-1:0] hw_wdata_i,
  output logic [RegWidth-1:0] q_o
);

  logic [RegWidth-1:0] mask;
  logic [RegWidth-1:0] sw_bits;
  logic [RegWidth-1:0] reg_q;
  logic [RegWidth-1:0] reg_d;

  for (genvar gi = 0; gi < RegWidth; gi++) begin : gen_mask
    assign mask[gi] = sw_be_i[gi/8];
  end

  assign sw_bits = sw_wdata_i & mask;

  // Hardware always wins; for W1C the sticky set is applied after the clear.
  always_comb begin
    reg_d = reg_q;
    case (Mode)
      REG_RW: begin
        if (hw_we_i)      reg_d = hw_wdata_i;
        else if (sw_we_i) reg_d = (reg_q & ~mask) | sw_bits;
      end
      REG_RO: begin
        if (hw_we_i) reg_d = hw_wdata_i;
      end
      REG_W1C: begin
        reg_d = reg_q & ~(sw_we_i ? sw_bits : '0);
        if (hw_we_i) reg_d = reg_d | hw_wdata_i;
      end
      REG_RC: begin
        if (hw_we_i)      reg_d = hw_wdata_i;
        else if (sw_re_i) reg_d = '0;
      end
      default: reg_d = reg_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) reg_q <= ResetVal;
    else         reg_q <= reg_d;
  end

  assign q_o = reg_q;

endmodule

// File: rtl/obi_regfile.sv
// OBI subordinate register file: address decode, grant, per-register cells
// and a single-stage response register.
module obi_regfile
  import croc_pkg::*;
#(
  parameter int unsigned                       NumRegs   = 4,
  parameter int unsigned                       RegWidth  = 32,
  parameter int unsigned                       AddrWidth = 12,
  parameter logic [NumRegs-1:0][1:0]           RegMode   = '0,
  parameter logic [NumRegs-1:0][RegWidth-1:0]  ResetVal  = '0
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  sbr_obi_req_t                       obi_req_i,
  output sbr_obi_rsp_t                       obi_rsp_o,
  input  logic [NumRegs-1:0]                 reg_ready_i,
  input  logic [NumRegs-1:0]                 hw_we_i,
  input  logic [NumRegs-1:0][RegWidth-1:0]   hw_wdata_i,
  output logic [NumRegs-1:0][RegWidth-1:0]   regs_o,
  output logic [NumRegs-1:0]                 sw_wr_o,
  output logic [NumRegs-1:0]                 sw_rd_o
);

  localparam int unsigned IdxWidth = AddrWidth - 2;

  logic [IdxWidth-1:0]        addr_idx;
  logic [NumRegs-1:0]         sel_hit;
  logic                       in_range;
  reg_mode_e                  mode_sel;
  logic                       ready_sel;
  logic [RegWidth-1:0]        reg_sel;
  logic                       illegal;
  logic                       gnt;
  logic                       accept;
  logic [31:0]                rdata_d;
  logic [NumRegs-1:0]         sw_we;
  logic [NumRegs-1:0]         sw_re;

  logic                       rvalid_q;
  logic                       err_q;
  logic [31:0]                rdata_q;
  logic [SbrObiIdWidth-1:0]   rid_q;
  logic [NumRegs-1:0]         sw_wr_q;
  logic [NumRegs-1:0]         sw_rd_q;

  // Upper address bits are decoded upstream; only the word index matters here.
  logic unused_req;
  assign unused_req = ^{obi_req_i.a.addr, obi_req_i.a.a_optional};

  assign addr_idx = obi_req_i.a.addr[AddrWidth-1:2];

  // One-hot compare against each implemented index keeps out-of-range
  // indices from ever addressing an array element.
  always_comb begin
    sel_hit   = '0;
    mode_sel  = REG_RW;
    ready_sel = 1'b0;
    reg_sel   = '0;
    for (int i = 0; i < int'(NumRegs); i++) begin
      if (addr_idx == IdxWidth'(i)) begin
        sel_hit[i] = 1'b1;
        mode_sel   = reg_mode_e'(RegMode[i]);
        ready_sel  = reg_ready_i[i];
        reg_sel    = regs_o[i];
      end
    end
  end

  assign in_range = |sel_hit;
  assign illegal  = !in_range ||
                    (obi_req_i.a.we && (mode_sel == REG_RO || mode_sel == REG_RC));
  assign gnt      = obi_req_i.req && (illegal || ready_sel);
  assign accept   = gnt;

  always_comb begin
    rdata_d = '0;
    if (!illegal) rdata_d[RegWidth-1:0] = reg_sel;
  end

  for (genvar gi = 0; gi < NumRegs; gi++) begin : gen_regs
    assign sw_we[gi] = accept && !illegal && sel_hit[gi] &&  obi_req_i.a.we;
    assign sw_re[gi] = accept && !illegal && sel_hit[gi] && !obi_req_i.a.we;

    obi_regfile_cell #(
      .RegWidth (RegWidth),
      .Mode     (reg_mode_e'(RegMode[gi])),
      .ResetVal (ResetVal[gi])
    ) i_cell (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .sw_we_i    (sw_we[gi]),
      .sw_re_i    (sw_re[gi]),
      .sw_wdata_i (obi_req_i.a.wdata[RegWidth-1:0]),
      .sw_be_i    (obi_req_i.a.be),
      .hw_we_i    (hw_we_i[gi]),
      .hw_wdata_i (hw_wdata_i[gi]),
      .q_o        (regs_o[gi])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      rid_q    <= '0;
      sw_wr_q  <= '0;
      sw_rd_q  <= '0;
    end else begin
      rvalid_q <= accept;
      sw_wr_q  <= sw_we;
      sw_rd_q  <= sw_re;
      if (accept) begin
        err_q   <= illegal;
        rdata_q <= rdata_d;
        rid_q   <= obi_req_i.a.aid;
      end
    end
  end

  assign sw_wr_o = sw_wr_q;
  assign sw_rd_o = sw_rd_q;

  always_comb begin
    obi_rsp_o              = '0;
    obi_rsp_o.gnt          = gnt;
    obi_rsp_o.rvalid       = rvalid_q;
    obi_rsp_o.r.rdata      = rdata_q;
    obi_rsp_o.r.rid        = rid_q;
    obi_rsp_o.r.err        = err_q;
    obi_rsp_o.r.r_optional = 1'b0;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rst_ni && accept && illegal)
      $warning("obi_regfile: illegal access addr=%h we=%b", obi_req_i.a.addr, obi_req_i.a.we);
  end
`endif

endmodule

// File: tb/tb_obi_regfile.sv
// Directed self-checking bench for obi_regfile with one register per mode:
// reg0 RW, reg1 RO, reg2 W1C, reg3 RC.
module tb_obi_regfile;
  import croc_pkg::*;

  logic                 clk_i;
  logic                 rst_ni;
  sbr_obi_req_t         obi_req;
  sbr_obi_rsp_t         obi_rsp;
  logic [3:0]           reg_ready;
  logic [3:0]           hw_we;
  logic [3:0][31:0]     hw_wdata;
  logic [3:0][31:0]     regs;
  logic [3:0]           sw_wr;
  logic [3:0]           sw_rd;

  int n_cmp = 0;
  int n_err = 0;

  obi_regfile #(
    .NumRegs   (4),
    .RegWidth  (32),
    .AddrWidth (12),
    .RegMode   ({2'd3, 2'd2, 2'd1, 2'd0}),
    .ResetVal  ({32'h55, 32'hFF, 32'hA, 32'h0})
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .obi_req_i   (obi_req),
    .obi_rsp_o   (obi_rsp),
    .reg_ready_i (reg_ready),
    .hw_we_i     (hw_we),
    .hw_wdata_i  (hw_wdata),
    .regs_o      (regs),
    .sw_wr_o     (sw_wr),
    .sw_rd_o     (sw_rd)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Called just after a negedge; returns at the negedge following the accept.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [3:0] aid,
                        output int waits, output logic rv, output logic [31:0] rd,
                        output logic er, output logic [3:0] ri,
                        output logic [3:0] wrp, output logic [3:0] rdp);
    obi_req.req     = 1'b1;
    obi_req.a.we    = we;
    obi_req.a.addr  = addr;
    obi_req.a.wdata = wdata;
    obi_req.a.be    = be;
    obi_req.a.aid   = aid;
    waits = 0;
    #1;
    while (!obi_rsp.gnt && waits < 20) begin
      @(negedge clk_i); #1;
      waits++;
    end
    if (!obi_rsp.gnt) begin
      n_cmp++; n_err++;
      $display("FAIL gnt_timeout: addr=%h no grant after %0d cycles, required grant", addr, waits);
      obi_req.req = 1'b0;
      rv = 1'b0; rd = '0; er = 1'b0; ri = '0; wrp = '0; rdp = '0;
      @(negedge clk_i);
      return;
    end
    @(posedge clk_i); #1;
    obi_req.req = 1'b0;
    @(negedge clk_i);
    rv  = obi_rsp.rvalid;
    rd  = obi_rsp.r.rdata;
    er  = obi_rsp.r.err;
    ri  = obi_rsp.r.rid;
    wrp = sw_wr;
    rdp = sw_rd;
    $display("txn we=%0d addr=%h wdata=%h be=%b aid=%0d waits=%0d -> rvalid=%0d rdata=%h err=%0d rid=%0d",
             we, addr, wdata, be, aid, waits, rv, rd, er, ri);
  endtask

  int          w;
  logic        rv, er;
  logic [31:0] rd;
  logic [3:0]  ri, wrp, rdp;

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    n_cmp++; if (obi_rsp.rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid: got %b req 0", obi_rsp.rvalid); end
    n_cmp++; if (regs !== {32'h55, 32'hFF, 32'hA, 32'h0}) begin n_err++; $display("FAIL reset_regs: got %h req 55/FF/A/0", regs); end
    n_cmp++; if ({sw_wr, sw_rd} !== 8'h00) begin n_err++; $display("FAIL reset_pulses: got %b req 0", {sw_wr, sw_rd}); end
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_read_reset_val();
    access(1'b0, 32'h4, 32'h0, 4'hF, 4'd3, w, rv, rd, er, ri, wrp, rdp);
    n_cmp++; if (rv !== 1'b1) begin n_err++; $display("FAIL rd1_rvalid: got %b req 1", rv); end
    n_cmp++; if (rd !== 32'h0000000A) begin n_err++; $display("FAIL rd1_rdata: got %h req 0000000a", rd); end
    n_cmp++; if (er !== 1'b0) begin n_err++; $display("FAIL rd1_err: got %b req 0", er); end
    n_cmp++; if (ri !== 4'd3) begin n_err++; $display("FAIL rd1_rid: got %0d req 3", ri); end
    n_cmp++; if (rdp !== 4'b0010 || wrp !== 4'b0000) begin n_err++; $display("FAIL rd1_pulses: got rd=%b wr=%b req rd=0010 wr=0000", rdp, wrp); end
    @(negedge clk_i);
    n_cmp++; if (obi_rsp.rvalid !== 1'b0) begin n_err++; $display("FAIL rd1_rvalid_once: got %b req 0", obi_rsp.rvalid); end
  endtask

  task automatic test_rw_byte_enable();
    access(1'b1, 32'h0, 32'hDEADBEEF, 4'b0101, 4'd1, w, rv, rd, er, ri, wrp, rdp);
    n_cmp++; if (regs[0] !== 32'h00AD00EF) begin n_err++; $display("FAIL rw_be_value: got %h req 00ad00ef", regs[0]); end
    n_cmp++; if (wrp !== 4'b0001) begin n_err++; $display("FAIL rw_be_wr_pulse: got %b req 0001", wrp); end
    n_cmp++; if (rv !== 1'b1 || er !== 1'b0 || rd !== 32'h0) begin n_err++; $display("FAIL rw_be_rsp: got rv=%b err=%b rdata=%h req 1/0/0", rv, er, rd); end
    @(negedge clk_i);
    n_cmp++; if (sw_wr !== 4'b0000) begin n_err++; $display("FAIL rw_be_pulse_once: got %b req 0000", sw_wr); end
  endtask

  task automatic test_w1c_collision();
    hw_we       = 4'b0100;
    hw_wdata[2] = 32'h01;
    access(1'b1, 32'h8, 32'h0F, 4'hF, 4'd2, w, rv, rd, er, ri, wrp, rdp);
    hw_we = 4'b0000;
    n_cmp++; if (regs[2] !== 32'hF1) begin n_err++; $display("FAIL w1c_value: got %h req 000000f1", regs[2]); end
    n_cmp++; if (er !== 1'b0 || rd !== 32'hFF) begin n_err++; $display("FAIL w1c_rsp: got err=%b rdata=%h req 0/000000ff", er, rd); end
    n_cmp++; if (wrp !== 4'b0100) begin n_err++; $display("FAIL w1c_wr_pulse: got %b req 0100", wrp); end
  endtask

  task automatic test_read_clear();
    access(1'b0, 32'hC, 32'h0, 4'hF, 4'd4, w, rv, rd, er, ri, wrp, rdp);
    n_cmp++; if (rd !== 32'h55) begin n_err++; $display("FAIL rc_first_rdata: got %h req 00000055", rd); end
    n_cmp++; if (regs[3] !== 32'h0) begin n_err++; $display("FAIL rc_cleared: got %h req 0", regs[3]); end
    n_cmp++; if (rdp !== 4'b1000) begin n_err++; $display("FAIL rc_rd_pulse: got %b req 1000", rdp); end
    access(1'b0, 32'hC, 32'h0, 4'hF, 4'd4, w, rv, rd, er, ri, wrp, rdp);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL rc_second_rdata: got %h req 0", rd); end
    hw_we       = 4'b1000;
    hw_wdata[3] = 32'h77;
    access(1'b0, 32'hC, 32'h0, 4'hF, 4'd4, w, rv, rd, er, ri, wrp, rdp);
    hw_we = 4'b0000;
    n_cmp++; if (regs[3] !== 32'h77) begin n_err++; $display("FAIL rc_hw_wins: got %h req 00000077", regs[3]); end
    access(1'b0, 32'hC, 32'h0, 4'hF, 4'd4, w, rv, rd, er, ri, wrp, rdp);
    n_cmp++; if (rd !== 32'h77 || regs[3] !== 32'h0) begin n_err++; $display("FAIL rc_hw_then_read: got rdata=%h reg=%h req 77/0", rd, regs[3]); end
  endtask

  task automatic test_illegal();
    reg_ready = 4'b0000;
    access(1'b1, 32'h4, 32'h1234, 4'hF, 4'd7, w, rv, rd, er, ri, wrp, rdp);
    n_cmp++; if (w !== 0) begin n_err++; $display("FAIL ro_wr_gnt_wait: got %0d cycles req 0", w); end
    n_cmp++; if (er !== 1'b1 || rd !== 32'h0 || rv !== 1'b1) begin n_err++; $display("FAIL ro_wr_rsp: got rv=%b err=%b rdata=%h req 1/1/0", rv, er, rd); end
    n_cmp++; if (wrp !== 4'b0000) begin n_err++; $display("FAIL ro_wr_no_pulse: got %b req 0000", wrp); end
    access(1'b1, 32'h10, 32'hFFFFFFFF, 4'hF, 4'd8, w, rv, rd, er, ri, wrp, rdp);
    n_cmp++; if (w !== 0 || er !== 1'b1 || wrp !== 4'b0000) begin n_err++; $display("FAIL oor_wr: got waits=%0d err=%b wr=%b req 0/1/0000", w, er, wrp); end
    access(1'b0, 32'h10, 32'h0, 4'hF, 4'd9, w, rv, rd, er, ri, wrp, rdp);
    n_cmp++; if (er !== 1'b1 || rd !== 32'h0 || rdp !== 4'b0000 || ri !== 4'd9) begin n_err++; $display("FAIL oor_rd: got err=%b rdata=%h rd=%b rid=%0d req 1/0/0000/9", er, rd, rdp, ri); end
    access(1'b1, 32'hC, 32'hABCD, 4'hF, 4'd10, w, rv, rd, er, ri, wrp, rdp);
    n_cmp++; if (er !== 1'b1 || w !== 0) begin n_err++; $display("FAIL rc_wr_illegal: got err=%b waits=%0d req 1/0", er, w); end
    n_cmp++; if (regs !== {32'h0, 32'hF1, 32'hA, 32'h00AD00EF}) begin n_err++; $display("FAIL illegal_regs_unchanged: got %h", regs); end
    reg_ready = 4'b1111;
  endtask

  task automatic test_back_to_back();
    obi_req.req     = 1'b1;
    obi_req.a.we    = 1'b1;
    obi_req.a.addr  = 32'h0;
    obi_req.a.wdata = 32'h11111111;
    obi_req.a.be    = 4'hF;
    obi_req.a.aid   = 4'd5;
    @(posedge clk_i); #1;
    obi_req.a.we  = 1'b0;
    obi_req.a.aid = 4'd6;
    n_cmp++; if (obi_rsp.gnt !== 1'b1) begin n_err++; $display("FAIL b2b_gnt2: got %b req 1", obi_rsp.gnt); end
    @(negedge clk_i);
    n_cmp++; if (obi_rsp.rvalid !== 1'b1 || obi_rsp.r.rid !== 4'd5 || sw_wr !== 4'b0001) begin n_err++; $display("FAIL b2b_rsp1: got rv=%b rid=%0d wr=%b req 1/5/0001", obi_rsp.rvalid, obi_rsp.r.rid, sw_wr); end
    @(posedge clk_i); #1;
    obi_req.req = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (obi_rsp.rvalid !== 1'b1 || obi_rsp.r.rid !== 4'd6 || obi_rsp.r.rdata !== 32'h11111111 || sw_rd !== 4'b0001) begin n_err++; $display("FAIL b2b_rsp2: got rv=%b rid=%0d rdata=%h rd=%b req 1/6/11111111/0001", obi_rsp.rvalid, obi_rsp.r.rid, obi_rsp.r.rdata, sw_rd); end
    $display("txn back-to-back write/read reg0 aid=5,6 rdata=%h", obi_rsp.r.rdata);
    @(negedge clk_i);
  endtask

  task automatic test_stall_and_reset();
    int low_cnt = 0;
    reg_ready = 4'b1101;
    obi_req.req    = 1'b1;
    obi_req.a.we   = 1'b0;
    obi_req.a.addr = 32'h4;
    obi_req.a.aid  = 4'd11;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (obi_rsp.gnt === 1'b0) low_cnt++;
      @(negedge clk_i);
    end
    n_cmp++; if (low_cnt !== 3) begin n_err++; $display("FAIL stall_gnt_low: got %0d low cycles req 3", low_cnt); end
    reg_ready = 4'b1111;
    #1;
    n_cmp++; if (obi_rsp.gnt !== 1'b1) begin n_err++; $display("FAIL stall_gnt_release: got %b req 1", obi_rsp.gnt); end
    @(posedge clk_i); #1;
    obi_req.req = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (obi_rsp.rvalid !== 1'b1 || obi_rsp.r.rdata !== 32'hA) begin n_err++; $display("FAIL stall_rsp: got rv=%b rdata=%h req 1/0000000a", obi_rsp.rvalid, obi_rsp.r.rdata); end
    $display("txn stalled read reg1 aid=11 rdata=%h", obi_rsp.r.rdata);
    @(negedge clk_i);
    // Reset lands between the accept edge and the response edge.
    obi_req.req    = 1'b1;
    obi_req.a.addr = 32'h0;
    @(posedge clk_i); #1;
    obi_req.req = 1'b0;
    rst_ni = 1'b0;
    #2;
    rst_ni = 1'b1;
    @(negedge clk_i);
    n_cmp++; if (obi_rsp.rvalid !== 1'b0 || sw_rd !== 4'b0000) begin n_err++; $display("FAIL reset_drops_rsp: got rv=%b rd=%b req 0/0000", obi_rsp.rvalid, sw_rd); end
    n_cmp++; if (regs !== {32'h55, 32'hFF, 32'hA, 32'h0}) begin n_err++; $display("FAIL reset_mid_regs: got %h req 55/FF/A/0", regs); end
    $display("txn read reg0 interrupted by reset");
  endtask

  initial begin
    rst_ni    = 1'b0;
    obi_req   = '0;
    reg_ready = 4'b1111;
    hw_we     = 4'b0000;
    hw_wdata  = '0;
    @(negedge clk_i);
    test_reset();
    test_read_reset_val();
    test_rw_byte_enable();
    test_w1c_collision();
    test_read_clear();
    test_illegal();
    test_back_to_back();
    test_stall_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
